// File: rtl/sipo_always_rx.sv
// sipo_always_rx: oversampling receiver for the piso_always link; latches a WIDTH-bit word on lock and echoes the last latched word on sdo.
// Define SIPO_GLITCH_FILTER_EN to add a 3-sample majority filter on sclk and lock (acts at N+4 instead of N+2).
module sipo_always_rx #(
    parameter int               WIDTH   = 24,
    parameter int               TIMEOUT = 720_000,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             sclr,
    input  logic             sclk,
    input  logic             sdi,
    input  logic             lock,
    output logic             sdo,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_err,
    output logic [7:0]       err_cnt,
    output logic             stale
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef SIPO_GLITCH_FILTER_EN
    localparam int SL = 4;
    localparam int DL = 4;
`else
    localparam int SL = 3;
    localparam int DL = 2;
`endif
    typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;
    state_t state;
    logic [SL-1:0] sclk_p, lock_p;
    logic [DL-1:0] sdi_p;
    logic sclk_rise, sclk_fall, lock_rise;
    logic [WIDTH-1:0] shift, echo;
    logic [CW-1:0] bit_cnt;
    logic [TW-1:0] timer;

    // synchronizers are cleared only by the asynchronous reset
    always_ff @(posedge clk or negedge aclr_n)
        if (!aclr_n) begin
            sclk_p <= '0;
            lock_p <= '0;
            sdi_p  <= '0;
        end else begin
            sclk_p <= {sclk_p[SL-2:0], sclk};
            lock_p <= {lock_p[SL-2:0], lock};
            sdi_p  <= {sdi_p[DL-2:0], sdi};
        end

`ifdef SIPO_GLITCH_FILTER_EN
    function automatic logic maj(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction
    logic [1:0] filt, filt_d;
    always_ff @(posedge clk or negedge aclr_n)
        if (!aclr_n) begin
            filt   <= '0;
            filt_d <= '0;
        end else begin
            filt   <= {maj(lock_p[3:1]), maj(sclk_p[3:1])};
            filt_d <= filt;
        end
    assign sclk_rise = filt[0] & ~filt_d[0];
    assign sclk_fall = ~filt[0] & filt_d[0];
    assign lock_rise = filt[1] & ~filt_d[1];
`else
    assign sclk_rise = sclk_p[1] & ~sclk_p[2];
    assign sclk_fall = ~sclk_p[1] & sclk_p[2];
    assign lock_rise = lock_p[1] & ~lock_p[2];
`endif

    always_ff @(posedge clk or negedge aclr_n)
        if (!aclr_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            echo      <= DEFAULT;
            sdo       <= DEFAULT[WIDTH-1];
            data      <= DEFAULT;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
            stale     <= 1'b0;
            timer     <= '0;
        end else if (sclr) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            echo      <= DEFAULT;
            sdo       <= DEFAULT[WIDTH-1];
            data      <= DEFAULT;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
            stale     <= 1'b0;
            timer     <= '0;
        end else begin
            valid <= 1'b0;
            sdo   <= echo[WIDTH-1];
            timer <= (timer == TW'(TIMEOUT - 1)) ? timer : timer + 1'b1;
            if (timer == TW'(TIMEOUT - 1))
                stale <= 1'b1;
            if (sclk_fall)
                echo <= {echo[WIDTH-2:0], 1'b0};
            // lock wins over a coincident sclk rise; that bit is dropped
            if (lock_rise) begin
                state   <= IDLE;
                bit_cnt <= '0;
                if (bit_cnt == CW'(WIDTH)) begin
                    echo  <= shift;
                    data  <= shift;
                    valid <= 1'b1;
                    timer <= '0;
                    stale <= 1'b0;
                end else begin
                    frame_err <= 1'b1;
                    err_cnt   <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                end
            end else if (sclk_rise && state != OVER) begin
                shift   <= {shift[WIDTH-2:0], sdi_p[DL-1]};
                bit_cnt <= bit_cnt + 1'b1;
                state   <= (bit_cnt == CW'(WIDTH)) ? OVER : SHIFT;
            end
        end
endmodule

// File: tb/tb_sipo_always_rx.sv
// tb_sipo_always_rx: table-driven frames plus hand-written stale, sclr and glitch sequences for sipo_always_rx.
module tb_sipo_always_rx;
    localparam int W = 24;
    localparam int TO = 3000;

    logic clk = 1'b0, aclr_n = 1'b0, sclr = 1'b0, sclk = 1'b0, sdi = 1'b0, lock = 1'b0;
    logic sdo, valid, frame_err, stale;
    logic [W-1:0] data;
    logic [7:0] err_cnt;

    int n_chk = 0, n_fail = 0, vcnt;
    logic [31:0] cap;
    logic stale_pre, stale_v;

    sipo_always_rx #(.WIDTH(W), .TIMEOUT(TO), .DEFAULT('0)) dut (
        .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .sclk(sclk), .sdi(sdi), .lock(lock),
        .sdo(sdo), .data(data), .valid(valid), .frame_err(frame_err), .err_cnt(err_cnt), .stale(stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        int          nb;
        logic [23:0] d;
        int          v;
        logic        fe;
        logic [7:0]  ec;
        logic        ce;
        logic [23:0] e;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CLK_DIV=18: 9 clk low, 9 clk high per bit; sdo sampled just before each sclk rise
    task automatic send_frame(input logic [31:0] w, input int nbits, input int sclr_at, input int glitch_at);
        cap = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (nbits - 1 - i == sclr_at) begin
                sclr = 1'b1;
                @(negedge clk);
                sclr = 1'b0;
                chk("sclr_data", 32'(data), 32'h0);
                chk("sclr_ferr", 32'(frame_err), 32'h0);
                chk("sclr_errcnt", 32'(err_cnt), 32'h0);
                chk("sclr_valid", 32'(valid), 32'h0);
                chk("sclr_stale", 32'(stale), 32'h0);
                @(negedge clk);
                chk("sclr_sdo", 32'(sdo), 32'h0);
            end
            sdi = w[i];
            repeat (4) @(negedge clk);
            if (nbits - 1 - i == glitch_at) begin
                sclk = 1'b1;
                @(negedge clk);
                sclk = 1'b0;
            end
            repeat (5) @(negedge clk);
            cap = {cap[30:0], sdo};
            sclk = 1'b1;
            repeat (9) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (9) @(negedge clk);
        stale_pre = stale;
        lock = 1'b1;
        vcnt = 0;
        stale_v = 1'b1;
        repeat (9) begin
            @(negedge clk);
            if (valid) begin
                vcnt++;
                stale_v = stale;
            end
        end
        lock = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{32'hA5C3F0,     24, 24'hA5C3F0, 1, 1'b0, 8'd0, 1'b1, 24'h000000};
        tbl[1] = '{32'h123456,     24, 24'h123456, 1, 1'b0, 8'd0, 1'b1, 24'hA5C3F0};
        tbl[2] = '{32'h5A5A5A,     23, 24'h123456, 0, 1'b1, 8'd1, 1'b0, 24'h000000};
        tbl[3] = '{32'h0F0F0F,     24, 24'h0F0F0F, 1, 1'b1, 8'd1, 1'b0, 24'h000000};
        tbl[4] = '{32'h3FFFFFFF,   30, 24'h0F0F0F, 0, 1'b1, 8'd2, 1'b0, 24'h000000};
        tbl[5] = '{32'hFFFFFF,     24, 24'hFFFFFF, 1, 1'b1, 8'd2, 1'b0, 24'h000000};
        tbl[6] = '{32'h000001,     24, 24'h000001, 1, 1'b1, 8'd2, 1'b1, 24'hFFFFFF};
        tbl[7] = '{32'h800000,     24, 24'h800000, 1, 1'b1, 8'd2, 1'b1, 24'h000001};
        tbl[8] = '{32'h0,           0, 24'h800000, 0, 1'b1, 8'd3, 1'b0, 24'h000000};
        tbl[9] = '{32'hC0FFEE,     24, 24'hC0FFEE, 1, 1'b1, 8'd3, 1'b1, 24'h800000};

        repeat (3) @(negedge clk);
        aclr_n = 1'b1;
        @(negedge clk);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_errcnt", 32'(err_cnt), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);
        chk("rst_sdo", 32'(sdo), 32'h0);

        for (int k = 0; k < 10; k++) begin
            send_frame(tbl[k].w, tbl[k].nb, -1, -1);
            chk($sformatf("v%0d_data", k), 32'(data), 32'(tbl[k].d));
            chk($sformatf("v%0d_valid_cycles", k), 32'(vcnt), 32'(tbl[k].v));
            chk($sformatf("v%0d_ferr", k), 32'(frame_err), 32'(tbl[k].fe));
            chk($sformatf("v%0d_errcnt", k), 32'(err_cnt), 32'(tbl[k].ec));
            chk($sformatf("v%0d_stale", k), 32'(stale), 32'h0);
            if (tbl[k].ce)
                chk($sformatf("v%0d_echo", k), 32'(cap[23:0]), 32'(tbl[k].e));
        end

        // sclr after 12 bits: the remaining 12 bits form a short frame
        send_frame(32'hABCDEF, 24, 12, -1);
        chk("post_sclr_data", 32'(data), 32'h0);
        chk("post_sclr_valid_cycles", 32'(vcnt), 32'h0);
        chk("post_sclr_ferr", 32'(frame_err), 32'h1);
        chk("post_sclr_errcnt", 32'(err_cnt), 32'h1);

`ifdef SIPO_GLITCH_FILTER_EN
        send_frame(32'h3C3C3C, 24, -1, 5);
        chk("glitch_data", 32'(data), 32'h3C3C3C);
        chk("glitch_valid_cycles", 32'(vcnt), 32'h1);
        chk("glitch_errcnt", 32'(err_cnt), 32'h1);
`endif

        aclr_n = 1'b0;
        @(negedge clk);
        aclr_n = 1'b1;
        repeat (TO - 1) @(posedge clk);
        #1 chk("stale_before_timeout", 32'(stale), 32'h0);
        @(posedge clk);
        #1 chk("stale_at_timeout", 32'(stale), 32'h1);
        @(negedge clk);
        send_frame(32'h654321, 24, -1, -1);
        chk("stale_during_frame", 32'(stale_pre), 32'h1);
        chk("stale_in_valid_cycle", 32'(stale_v), 32'h0);
        chk("stale_frame_valid_cycles", 32'(vcnt), 32'h1);
        chk("stale_frame_data", 32'(data), 32'h654321);
        chk("stale_after_frame", 32'(stale), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
